// File: rtl/fifo_stream_drain.sv
// Drain stage for the 32-bit word FIFO: turns its rd_en/empty/registered-data
// read port into a valid/ready stream, tracking reads in flight across RD_LATENCY.
module fifo_stream_drain #(
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic        flush,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        busy,
  output logic [31:0] words_out
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(RD_LATENCY + 1);

  logic [RD_LATENCY-1:0]      r_tag, r_disc;
  logic [BUF_DEPTH-1:0][31:0] r_mem;
  logic [PW-1:0]              r_head, r_tail;
  logic [CW-1:0]              r_count;
  logic [31:0]                r_words_out;

  logic [IW-1:0]         w_inflight;
  logic [RD_LATENCY-1:0] w_tag_nx, w_disc_nx;
  logic [7:0]            w_used;
  logic                  w_pop, w_land;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight += IW'(r_tag[i]);
  end

  assign m_valid   = (r_count != '0);
  assign m_data    = r_mem[r_head];
  assign w_pop     = m_valid && m_ready;
  assign busy      = m_valid || (w_inflight != '0);
  assign words_out = r_words_out;

  // Credits: buffered + in-flight words (net of this cycle's pop) must fit the buffer.
  assign w_used     = 8'(r_count) + 8'(w_inflight) - 8'(w_pop);
  assign fifo_rd_en = resetn && enable && !flush && !fifo_empty && (w_used < 8'(BUF_DEPTH));

  // Tags shift toward the MSB; the MSB is the read whose data is on fifo_data now.
  assign w_land    = r_tag[RD_LATENCY-1] && !r_disc[RD_LATENCY-1] && !flush;
  assign w_tag_nx  = (r_tag << 1) | RD_LATENCY'(fifo_rd_en);
  assign w_disc_nx = (r_disc << 1) | (flush ? w_tag_nx : '0);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_tag       <= '0;
      r_disc      <= '0;
      r_count     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_words_out <= '0;
    end else begin
      r_tag  <= w_tag_nx;
      r_disc <= w_disc_nx;
      if (w_pop) r_words_out <= r_words_out + 32'd1;
      if (flush) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_land) begin
          r_mem[r_tail] <= fifo_data;
          r_tail        <= nxt(r_tail);
        end
        if (w_pop) r_head <= nxt(r_head);
        r_count <= r_count + CW'(w_land) - CW'(w_pop);
      end
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!resetn) r_count <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural 1-cycle-latency FIFO feeding the DUT,
// scoreboard of loaded words compared against delivered words.
module tb_fifo_stream_drain;
  logic        clock = 1'b0, resetn = 1'b0, enable = 1'b0, flush = 1'b0;
  logic        fifo_empty = 1'b1, m_ready = 1'b0;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd_en, m_valid, busy;
  logic [31:0] m_data, words_out;

  fifo_stream_drain #(.RD_LATENCY(1)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .words_out(words_out)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int reads = 0, delivered = 0;
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  logic gap = 1'b0, gap_mode = 1'b0, acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FIFO model: accepted read at an edge presents the word just after that edge.
  always @(posedge clock) begin
    acc = fifo_rd_en && !fifo_empty;
    #1;
    if (acc && fq.size() > 0) fifo_data = fq.pop_front();
    gap = gap_mode ? ~gap : 1'b0;
    fifo_empty = (fq.size() == 0) || gap;
  end

  // Monitor: events seen at the negedge take effect at the following posedge.
  always @(negedge clock) begin
    if (fifo_rd_en) begin
      chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      reads++;
    end
    if (m_valid && m_ready) begin
      chk("deliver", m_data, (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF);
      delivered++;
    end
    if (flush) begin
      for (int i = 0; i < reads - delivered; i++)
        if (sb.size() > 0) void'(sb.pop_front());
      delivered = reads;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 32'(i));
      sb.push_back(base + 32'(i));
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      smp();
      if (sb.size() == 0 && !m_valid && !busy) break;
    end
    chk({tag, "_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    enable = 1'b1; m_ready = 1'b1;
    load(32'd1, 16);
    // Reset held with data available and enable high
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_words", words_out, 32'd0);
    end
    step(); resetn = 1'b1;

    // Streaming: first word in cycle 2, then one per cycle
    for (int c = 0; c <= 18; c++) begin
      smp();
      if (c == 0) chk("stream_rd0", {31'd0, fifo_rd_en}, 32'd1);
      if (c == 1) chk("stream_v1", {31'd0, m_valid}, 32'd0);
      if (c >= 2 && c <= 17) begin
        chk("stream_v", {31'd0, m_valid}, 32'd1);
        chk("stream_d", m_data, 32'(c - 1));
      end
      if (c == 18) begin
        chk("stream_end_v", {31'd0, m_valid}, 32'd0);
        chk("stream_words", words_out, 32'd16);
      end
    end

    // Backpressure: only BUF_DEPTH reads, head word held
    step(); m_ready = 1'b0; load(32'h100, 8);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (fifo_rd_en) n++;
      if (i >= 5) begin
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_hold", m_data, 32'h100);
      end
    end
    chk("bp_reads", 32'(n), 32'd2);
    step(); m_ready = 1'b1;
    drain("bp", 50);
    chk("bp_words", words_out, 32'd24);

    // Flush one cycle after the 2nd read, consumer stalled
    step(); m_ready = 1'b0; load(32'h200, 6);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      smp();
      if (fifo_rd_en) n++;
    end
    chk("fl_reads", 32'(n), 32'd2);
    step(); flush = 1'b1;
    smp();
    chk("fl_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("fl_busy", {31'd0, busy}, 32'd1);
    step(); flush = 1'b0; m_ready = 1'b1;
    smp();
    chk("fl_valid", {31'd0, m_valid}, 32'd0);
    chk("fl_busy_clr", {31'd0, busy}, 32'd0);
    drain("fl", 50);
    chk("fl_words", words_out, 32'd28);

    // Enable gating, then reads only on non-empty cycles
    step(); enable = 1'b0; load(32'h300, 4);
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("en_off_rd", {31'd0, fifo_rd_en}, 32'd0);
    end
    step(); gap_mode = 1'b1; enable = 1'b1;
    drain("gap", 60);
    chk("gap_words", words_out, 32'd32);
    step(); gap_mode = 1'b0;

    // Counter wrap
    step(); dut.r_words_out = 32'hFFFF_FFFE;
    step(); load(32'h400, 3);
    drain("wrap", 40);
    chk("wrap_words", words_out, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
